decode_queue_ctrl: RTL and testbench

DECODE_QUEUE_CTRL -- requirements
Module: decode_queue_ctrl

---
 rtl/decode_pkg.sv | 22 ++
 rtl/instruction_decoder.sv | 21 ++
 rtl/decode_queue_ctrl.sv | 113 +++++++++++
 tb/tb_decode_queue_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode queue: default depth, queue FSM states and
// the opcodes whose encodings carry no destination register.
package decode_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2,
    ST_FLUSH   = 2'd3
  } q_state_e;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // S-type and B-type encodings reuse instr[11:7] as immediate bits.
  function automatic logic writes_rd(input logic [6:0] opcode);
    return !((opcode == OP_STORE) || (opcode == OP_BRANCH));
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Purely combinational field extraction for one 32-bit RISC-V instruction word.
module instruction_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  func3,
  output logic [6:0]  func7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd
);

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign func7  = instr[31:25];
  assign rd     = writes_rd(instr[6:0]) ? instr[11:7] : 5'd0;

endmodule

// File: rtl/decode_queue_ctrl.sv
// Instruction queue between fetch and dispatch with flush support; the head
// entry is decoded combinationally so dispatch sees fields with no extra latency.
module decode_queue_ctrl
  import decode_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_valid_i,
  input  logic [31:0]                fetch_instr_i,
  input  logic [31:0]                fetch_pc_i,
  output logic                       fetch_ready_o,
  input  logic                       flush_i,
  output logic                       disp_valid_o,
  input  logic                       disp_ready_i,
  output logic [31:0]                disp_pc_o,
  output logic [4:0]                 disp_rs1_o,
  output logic [4:0]                 disp_rs2_o,
  output logic [4:0]                 disp_rd_o,
  output logic [6:0]                 disp_opcode_o,
  output logic [2:0]                 disp_func3_o,
  output logic [6:0]                 disp_func7_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  q_state_e      state;
  q_state_e      state_nxt;
  logic          push;
  logic          pop;

  // Handshakes use only registered ready/valid, so no combinational path from
  // disp_ready_i to fetch_ready_o exists.
  assign push = fetch_valid_i & fetch_ready_o;
  assign pop  = disp_valid_o & disp_ready_i;

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = ST_PARTIAL;
    if (state == ST_FLUSH) begin
      state_nxt = ST_EMPTY;
    end else if (count_nxt == '0) begin
      state_nxt = ST_EMPTY;
    end else if (count_nxt == FULL_CNT) begin
      state_nxt = ST_FULL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_EMPTY;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fetch_ready_o <= 1'b1;
      disp_valid_o  <= 1'b0;
    end else if (flush_i) begin
      state         <= ST_FLUSH;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fetch_ready_o <= 1'b0;
      disp_valid_o  <= 1'b0;
    end else begin
      state         <= state_nxt;
      count         <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fetch_ready_o <= (state_nxt == ST_EMPTY) || (state_nxt == ST_PARTIAL);
      disp_valid_o  <= (state_nxt == ST_PARTIAL) || (state_nxt == ST_FULL);
    end
  end

  // Entry storage carries no reset; validity is tracked by count and pointers.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      instr_q[wr_ptr] <= fetch_instr_i;
      pc_q[wr_ptr]    <= fetch_pc_i;
    end
  end

  assign count_o   = count;
  assign disp_pc_o = pc_q[rd_ptr];

  instruction_decoder u_decoder (
    .instr  (instr_q[rd_ptr]),
    .opcode (disp_opcode_o),
    .func3  (disp_func3_o),
    .func7  (disp_func7_o),
    .rs1    (disp_rs1_o),
    .rs2    (disp_rs2_o),
    .rd     (disp_rd_o)
  );

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Directed and randomized checks of decode_queue_ctrl against a queue-based model.
module tb_decode_queue_ctrl;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_valid_i;
  logic [31:0]   fetch_instr_i;
  logic [31:0]   fetch_pc_i;
  logic          fetch_ready_o;
  logic          flush_i;
  logic          disp_valid_o;
  logic          disp_ready_i;
  logic [31:0]   disp_pc_o;
  logic [4:0]    disp_rs1_o;
  logic [4:0]    disp_rs2_o;
  logic [4:0]    disp_rd_o;
  logic [6:0]    disp_opcode_o;
  logic [2:0]    disp_func3_o;
  logic [6:0]    disp_func7_o;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;

  // Model: queue of {pc, instr}; flushing marks the single cycle after a flush.
  logic [63:0] q[$];
  bit          flushing = 0;

  always #5 clk = ~clk;

  decode_queue_ctrl #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_valid_i (fetch_valid_i),
    .fetch_instr_i (fetch_instr_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_ready_o (fetch_ready_o),
    .flush_i       (flush_i),
    .disp_valid_o  (disp_valid_o),
    .disp_ready_i  (disp_ready_i),
    .disp_pc_o     (disp_pc_o),
    .disp_rs1_o    (disp_rs1_o),
    .disp_rs2_o    (disp_rs2_o),
    .disp_rd_o     (disp_rd_o),
    .disp_opcode_o (disp_opcode_o),
    .disp_func3_o  (disp_func3_o),
    .disp_func7_o  (disp_func7_o),
    .count_o       (count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [31:0] h;
    logic [6:0]  op;
    bit          exp_rdy;
    bit          exp_vld;
    exp_rdy = !flushing && (q.size() < DEPTH);
    exp_vld = !flushing && (q.size() > 0);
    chk("count", 32'(count_o), 32'(q.size()));
    chk("fetch_ready", 32'(fetch_ready_o), 32'(exp_rdy));
    chk("disp_valid", 32'(disp_valid_o), 32'(exp_vld));
    if (exp_vld && disp_valid_o) begin
      h  = q[0][31:0];
      op = h[6:0];
      chk("pc", disp_pc_o, q[0][63:32]);
      chk("opcode", 32'(disp_opcode_o), 32'(op));
      chk("func3", 32'(disp_func3_o), 32'(h[14:12]));
      chk("func7", 32'(disp_func7_o), 32'(h[31:25]));
      chk("rs1", 32'(disp_rs1_o), 32'(h[19:15]));
      chk("rs2", 32'(disp_rs2_o), 32'(h[24:20]));
      chk("rd", 32'(disp_rd_o), (op == 7'h23 || op == 7'h63) ? 32'd0 : 32'(h[11:7]));
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                      input bit dr, input bit fl);
    bit do_push;
    bit do_pop;
    fetch_valid_i = fv;
    fetch_instr_i = ins;
    fetch_pc_i    = pc;
    disp_ready_i  = dr;
    flush_i       = fl;
    do_push = fv && !flushing && (q.size() < DEPTH);
    do_pop  = dr && !flushing && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
      flushing = 1;
    end else begin
      flushing = 0;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({pc, ins});
    end
    #1;
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [5];
    logic [31:0] w;
    ops[0] = 7'h13; ops[1] = 7'h23; ops[2] = 7'h63; ops[3] = 7'h33; ops[4] = 7'h03;
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 4)];
    return w;
  endfunction

  initial begin
    rst_n = 1'b0;
    fetch_valid_i = 1'b0; fetch_instr_i = '0; fetch_pc_i = '0;
    disp_ready_i = 1'b0; flush_i = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(disp_valid_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(fetch_ready_o), 32'd1);
    check_model();

    // Single addi, one-cycle push-to-dispatch latency
    step(1'b1, 32'h00500093, 32'h100, 1'b0, 1'b0);
    chk("addi_valid", 32'(disp_valid_o), 32'd1);
    chk("addi_rd", 32'(disp_rd_o), 32'd1);
    chk("addi_rs1", 32'(disp_rs1_o), 32'd0);
    chk("addi_op", 32'(disp_opcode_o), 32'h13);
    chk("addi_count", 32'(count_o), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill to FULL, fifth offer refused, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, rand_instr(), 32'(i * 4), 1'b0, 1'b0);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(fetch_ready_o), 32'd0);
    step(1'b1, 32'h00000013, 32'h10, 1'b0, 1'b0);
    chk("fifth_count", 32'(count_o), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", disp_pc_o, 32'(i * 4));
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Store and branch heads have no destination register
    step(1'b1, 32'h00112023, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h00208463, 32'h204, 1'b0, 1'b0);
    chk("sw_rd", 32'(disp_rd_o), 32'd0);
    chk("sw_rs1", 32'(disp_rs1_o), 32'd2);
    chk("sw_rs2", 32'(disp_rs2_o), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("beq_rd", 32'(disp_rd_o), 32'd0);
    chk("beq_pc", disp_pc_o, 32'h204);

    // Flush with simultaneous push and pop at count 2
    step(1'b1, rand_instr(), 32'h300, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(count_o), 32'd2);
    step(1'b1, rand_instr(), 32'h304, 1'b1, 1'b1);
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_ready", 32'(fetch_ready_o), 32'd0);
    chk("flush_valid", 32'(disp_valid_o), 32'd0);
    idle();
    chk("post_flush_ready", 32'(fetch_ready_o), 32'd1);
    // Held flush keeps the queue frozen
    step(1'b1, rand_instr(), 32'h400, 1'b0, 1'b1);
    step(1'b1, rand_instr(), 32'h404, 1'b0, 1'b1);
    chk("held_flush_ready", 32'(fetch_ready_o), 32'd0);
    idle();

    // Streaming at count 1 across pointer wrap
    step(1'b1, rand_instr(), 32'h500, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, rand_instr(), 32'h500 + 32'(i * 4), 1'b1, 1'b0);
      chk("stream_count", 32'(count_o), 32'd1);
      chk("stream_pc", disp_pc_o, 32'h500 + 32'(i * 4));
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges at count 3
    for (int i = 0; i < 3; i++) step(1'b1, rand_instr(), 32'h600 + 32'(i * 4), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count_o), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(count_o), 32'd0);
    chk("async_rst_valid", 32'(disp_valid_o), 32'd0);
    q.delete();
    flushing = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_model();

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom & 32'hFFFF_FFFC,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 29) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
